// File: rtl/bist_pattern_ctrl_if.sv
// BIST wrapper bus: run request, CUT pattern/response, status and signature.
// slave = BIST controller side, master = environment/CUT side.
interface bist_pattern_ctrl_if #(
  parameter int PAT_W  = 4,
  parameter int RSP_W  = 1,
  parameter int MISR_W = 16
);
  logic              start;
  logic [RSP_W-1:0]  rsp_i;
  logic [PAT_W-1:0]  pat_o;
  logic              busy;
  logic              done;
  logic [MISR_W-1:0] signature;
  logic              pass;

  modport slave (
    input  start, rsp_i,
    output pat_o, busy, done, signature, pass
  );

  modport master (
    output start, rsp_i,
    input  pat_o, busy, done, signature, pass
  );
endinterface

// File: rtl/bist_pattern_ctrl.sv
// BIST pattern controller: LFSR patterns into a CUT, MISR over its responses.
// Ports: CK, RST (sync, high), bus (start,rsp_i,pat_o,busy,done,signature,pass).
// Optional golden compare on DONE entry: define BIST_GOLDEN_CMP_EN.
module bist_pattern_ctrl #(
  parameter int                PAT_W       = 4,
  parameter int                RSP_W       = 1,
  parameter int                LFSR_W      = 8,
  parameter logic [LFSR_W-1:0] LFSR_POLY   = 8'hB8,
  parameter logic [LFSR_W-1:0] LFSR_SEED   = 8'h01,
  parameter int                MISR_W      = 16,
  parameter logic [MISR_W-1:0] MISR_POLY   = 16'h002D,
  parameter int                N_PATTERNS  = 255,
  parameter int                INIT_CYCLES = 4,
  parameter int                RSP_LAT     = 0,
  parameter logic [MISR_W-1:0] GOLDEN_SIG  = '0
) (
  input logic CK,
  input logic RST,
  bist_pattern_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, INIT, RUN, DRAIN, DONE
  } state_t;

  // An all-zero seed would lock the LFSR.
  localparam logic [LFSR_W-1:0] SEED =
    (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;

  localparam int CMAX =
    (N_PATTERNS > INIT_CYCLES) ?
      ((N_PATTERNS > RSP_LAT) ? N_PATTERNS : RSP_LAT) :
      ((INIT_CYCLES > RSP_LAT) ? INIT_CYCLES : RSP_LAT);
  localparam int CNT_W = $clog2(CMAX + 1);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [LFSR_W-1:0] lfsr, lfsr_n;
  logic [MISR_W-1:0] misr, misr_n;
  logic [PAT_W-1:0]  pat_q, pat_n;
  logic              busy_q, done_q;
  logic              run_v, dvalid;

  function automatic logic [LFSR_W-1:0] lfsr_step(
    input logic [LFSR_W-1:0] l
  );
    return l[0] ? ((l >> 1) ^ LFSR_POLY) : (l >> 1);
  endfunction

  function automatic logic [MISR_W-1:0] misr_step(
    input logic [MISR_W-1:0] m,
    input logic [RSP_W-1:0]  r
  );
    logic [MISR_W-1:0] fb;
    fb = m[MISR_W-1] ? MISR_POLY : '0;
    return (m << 1) ^ fb ^ MISR_W'(r);
  endfunction

  // Valid bit marks RUN cycles; delayed by RSP_LAT it
  // marks the cycles whose rsp_i belongs to a pattern.
  assign run_v = (state == RUN);

  generate
    if (RSP_LAT == 0) begin : g_nolat
      assign dvalid = run_v;
    end else begin : g_lat
      logic [RSP_LAT-1:0] vpipe;
      always_ff @(posedge CK) begin
        if (RST) vpipe <= '0;
        else     vpipe <= (vpipe << 1) | RSP_LAT'(run_v);
      end
      assign dvalid = vpipe[RSP_LAT-1];
    end
  endgenerate

  logic last_init, last_run, last_drain;
  assign last_init  = (cnt == CNT_W'(INIT_CYCLES - 1));
  assign last_run   = (cnt == CNT_W'(N_PATTERNS - 1));
  assign last_drain = (cnt == CNT_W'(RSP_LAT - 1));

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_n = INIT;
          cnt_n   = '0;
        end
      end
      INIT: begin
        if (last_init) begin
          state_n = RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RUN: begin
        if (last_run) begin
          state_n = (RSP_LAT == 0) ? DONE : DRAIN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (last_drain) begin
          state_n = DONE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are computed from the next state so that
  // pat_o/busy/done change together with the state.
  always_comb begin
    lfsr_n = lfsr;
    misr_n = misr;
    pat_n  = '0;
    if (state_n == INIT) begin
      lfsr_n = SEED;
      misr_n = '0;
    end else begin
      if (dvalid) misr_n = misr_step(misr, bus.rsp_i);
      if (state_n == RUN) begin
        pat_n  = lfsr[PAT_W-1:0];
        lfsr_n = lfsr_step(lfsr);
      end
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= '0;
      lfsr   <= SEED;
      misr   <= '0;
      pat_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      lfsr   <= lfsr_n;
      misr   <= misr_n;
      pat_q  <= pat_n;
      busy_q <= (state_n == INIT) || (state_n == RUN) ||
                (state_n == DRAIN);
      done_q <= (state_n == DONE);
    end
  end

`ifdef BIST_GOLDEN_CMP_EN
  logic pass_q;
  always_ff @(posedge CK) begin
    if (RST)                    pass_q <= 1'b0;
    else if (state_n != DONE)   pass_q <= 1'b0;
    else if (state != DONE)     pass_q <= (misr_n == GOLDEN_SIG);
  end
  assign bus.pass = pass_q;
`else
  // Keeps GOLDEN_SIG referenced; no comparator is built.
  logic unused_golden;
  assign unused_golden = ^GOLDEN_SIG;
  assign bus.pass      = 1'b0;
`endif

  assign bus.pat_o     = pat_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.signature = misr;

endmodule

// File: tb/tb_bist_pattern_ctrl.sv
// Random + directed bench for bist_pattern_ctrl, three configurations.
// Reference: per-run timeline model (cycles since start) and MISR arithmetic.
module tb_bist_pattern_ctrl;
  logic CK = 1'b0;
  logic RST;
  always #5 CK = ~CK;

  localparam int NI = 3;
  localparam int CI[NI]  = '{4, 4, 3};
  localparam int CN[NI]  = '{15, 4, 20};
  localparam int CL[NI]  = '{0, 0, 2};
  localparam int CMW[NI] = '{8, 8, 16};
  localparam int CMP[NI] = '{'h1D, 'h1D, 'h2D};
  localparam int CG[NI]  = '{'h0E, 'h0F, 'h0000};
  localparam int CPW[NI] = '{4, 4, 4};
  localparam int CLW[NI] = '{4, 4, 8};
  localparam int CLP[NI] = '{'hC, 'hC, 'hB8};
  localparam int CRW[NI] = '{1, 1, 2};
  localparam int SEQ[15] = '{1, 'hC, 6, 3, 'hD, 'hA, 5,
                             'hE, 7, 'hF, 'hB, 9, 8, 4, 2};

  bist_pattern_ctrl_if #(.PAT_W(4), .RSP_W(1), .MISR_W(8)) ifa ();
  bist_pattern_ctrl_if #(.PAT_W(4), .RSP_W(1), .MISR_W(8)) ifb ();
  bist_pattern_ctrl_if #(.PAT_W(4), .RSP_W(2), .MISR_W(16)) ifc ();

  bist_pattern_ctrl #(
    .PAT_W(4), .RSP_W(1), .LFSR_W(4), .LFSR_POLY(4'hC),
    .LFSR_SEED(4'h1), .MISR_W(8), .MISR_POLY(8'h1D),
    .N_PATTERNS(15), .INIT_CYCLES(4), .RSP_LAT(0),
    .GOLDEN_SIG(8'h0E)
  ) ua (.CK(CK), .RST(RST), .bus(ifa));

  bist_pattern_ctrl #(
    .PAT_W(4), .RSP_W(1), .LFSR_W(4), .LFSR_POLY(4'hC),
    .LFSR_SEED(4'h1), .MISR_W(8), .MISR_POLY(8'h1D),
    .N_PATTERNS(4), .INIT_CYCLES(4), .RSP_LAT(0),
    .GOLDEN_SIG(8'h0F)
  ) ub (.CK(CK), .RST(RST), .bus(ifb));

  bist_pattern_ctrl #(
    .PAT_W(4), .RSP_W(2), .LFSR_W(8), .LFSR_POLY(8'hB8),
    .LFSR_SEED(8'h01), .MISR_W(16), .MISR_POLY(16'h002D),
    .N_PATTERNS(20), .INIT_CYCLES(3), .RSP_LAT(2),
    .GOLDEN_SIG(16'h0000)
  ) uc (.CK(CK), .RST(RST), .bus(ifc));

  logic       start;
  logic [1:0] rsp[NI];

  assign ifa.start = start;
  assign ifb.start = start;
  assign ifc.start = start;
  assign ifa.rsp_i = rsp[0][0];
  assign ifb.rsp_i = rsp[1][0];
  assign ifc.rsp_i = rsp[2];

  logic [15:0] o_pat[NI], o_sig[NI];
  logic        o_busy[NI], o_done[NI], o_pass[NI];

  always_comb begin
    o_pat[0]  = 16'(ifa.pat_o);
    o_pat[1]  = 16'(ifb.pat_o);
    o_pat[2]  = 16'(ifc.pat_o);
    o_sig[0]  = 16'(ifa.signature);
    o_sig[1]  = 16'(ifb.signature);
    o_sig[2]  = ifc.signature;
    o_busy[0] = ifa.busy;
    o_busy[1] = ifb.busy;
    o_busy[2] = ifc.busy;
    o_done[0] = ifa.done;
    o_done[1] = ifb.done;
    o_done[2] = ifc.done;
    o_pass[0] = ifa.pass;
    o_pass[1] = ifb.pass;
    o_pass[2] = ifc.pass;
  end

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  // Model: mode 0=idle 1=active 2=done; k=cycles since start.
  int mode[NI], k[NI], sig[NI], pas[NI];
  int pats[NI][$];
  logic cap;
  int capq[$];

  function automatic int mstep(int m, int r, int w, int p);
    int fb, mask;
    fb   = (m >> (w - 1)) & 1;
    mask = (1 << w) - 1;
    return ((m << 1) & mask) ^ (fb != 0 ? p : 0) ^ r;
  endfunction

  task automatic chk(string nm, int d,
                     logic [31:0] got, logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s[%0d] cyc=%0d got=%0h exp=%0h",
               nm, d, cyc, got, exp);
    end
  endtask

  function automatic bit in_run(int d);
    return mode[d] == 1 && k[d] >= CI[d] + 1 &&
           k[d] <= CI[d] + CN[d];
  endfunction

  task automatic model_next();
    for (int d = 0; d < NI; d++) begin
      int r;
      r = int'(rsp[d]) & ((1 << CRW[d]) - 1);
      if (RST) begin
        mode[d] = 0; k[d] = 0; sig[d] = 0; pas[d] = 0;
      end else if (mode[d] != 1) begin
        if (start) begin
          mode[d] = 1; k[d] = 1; sig[d] = 0; pas[d] = 0;
        end
      end else begin
        if (k[d] >= CI[d] + 1 + CL[d] &&
            k[d] <= CI[d] + CN[d] + CL[d])
          sig[d] = mstep(sig[d], r, CMW[d], CMP[d]);
        k[d]++;
        if (k[d] > CI[d] + CN[d] + CL[d]) begin
          mode[d] = 2;
          pas[d]  = (sig[d] == CG[d]) ? 1 : 0;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < NI; d++) begin
      int ep, epass;
      ep = in_run(d) ? pats[d][k[d] - CI[d] - 1] : 0;
`ifdef BIST_GOLDEN_CMP_EN
      epass = (mode[d] == 2) ? pas[d] : 0;
`else
      epass = 0;
`endif
      chk("pat_o", d, 32'(o_pat[d]), ep);
      chk("busy", d, 32'(o_busy[d]), (mode[d] == 1) ? 1 : 0);
      chk("done", d, 32'(o_done[d]), (mode[d] == 2) ? 1 : 0);
      chk("signature", d, 32'(o_sig[d]), sig[d]);
      chk("pass", d, 32'(o_pass[d]), epass);
    end
  endtask

  task automatic step();
    model_next();
    @(negedge CK);
    cyc++;
    check_all();
    if (cap && in_run(0)) capq.push_back(int'(o_pat[0]));
  endtask

  task automatic wait_all_done(string nm);
    int i;
    for (i = 0; i < 80; i++) begin
      if (o_done[0] && o_done[1] && o_done[2]) break;
      step();
    end
    if (!(o_done[0] && o_done[1] && o_done[2])) begin
      nchk++;
      nerr++;
      $display("FAIL %s timeout got=notdone exp=done", nm);
    end
  endtask

  task automatic set_rsp(int v);
    for (int d = 0; d < NI; d++)
      rsp[d] = 2'(v & ((1 << CRW[d]) - 1));
  endtask

  int s_a, s_c, m;
  bit exp_pb;

  initial begin
    for (int d = 0; d < NI; d++) begin
      int l;
      mode[d] = 0; k[d] = 0; sig[d] = 0; pas[d] = 0;
      l = 1;
      for (int j = 0; j < CN[d]; j++) begin
        pats[d].push_back(l & ((1 << CPW[d]) - 1));
        l = ((l & 1) != 0) ? ((l >> 1) ^ CLP[d]) : (l >> 1);
        l = l & ((1 << CLW[d]) - 1);
      end
    end
    cap = 1'b0;

    // Pin the model against hand-worked values.
    m = 0;
    repeat (4) m = mstep(m, 1, 8, 'h1D);
    chk("pin_misr4", 0, m, 'h0F);
    repeat (5) m = mstep(m, 1, 8, 'h1D);
    chk("pin_misr9", 0, m, 'hE2);
    for (int j = 0; j < 15; j++)
      chk("pin_lfsr", j, pats[0][j], SEQ[j]);

    RST = 1'b1;
    start = 1'b0;
    set_rsp(0);
    repeat (3) step();
    RST = 1'b0;
    step();

    // Constant-one response run.
    set_rsp(3);
    cap = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_all_done("run1");
    cap = 1'b0;
    chk("seq_len", 0, capq.size(), 15);
    for (int j = 0; j < 15 && j < capq.size(); j++)
      chk("seq_pat", j, capq[j], SEQ[j]);
    chk("sig_n15", 0, 32'(o_sig[0]), 'h1D);
    chk("sig_n4", 1, 32'(o_sig[1]), 'h0F);
`ifdef BIST_GOLDEN_CMP_EN
    exp_pb = 1'b1;
`else
    exp_pb = 1'b0;
`endif
    chk("pass_match", 1, 32'(o_pass[1]), 32'(exp_pb));
    chk("pass_miss", 0, 32'(o_pass[0]), 0);
    s_a = int'(o_sig[0]);
    s_c = int'(o_sig[2]);

    // Restart from DONE reproduces the signature.
    start = 1'b1;
    step();
    start = 1'b0;
    wait_all_done("rerun");
    chk("rerun_sig", 0, 32'(o_sig[0]), s_a);
    chk("rerun_sig", 2, 32'(o_sig[2]), s_c);

    // Zero response.
    set_rsp(0);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_all_done("zero");
    for (int d = 0; d < NI; d++)
      chk("zero_sig", d, 32'(o_sig[d]), 0);

    // Ones only during INIT.
    start = 1'b1;
    step();
    start = 1'b0;
    set_rsp(1);
    repeat (4) step();
    set_rsp(0);
    wait_all_done("initmask");
    chk("init_mask", 0, 32'(o_sig[0]), 0);
    chk("init_mask", 1, 32'(o_sig[1]), 0);

    // Ones only in the DRAIN cycles of the latency build.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 80 && !o_done[2]; i++) begin
      set_rsp(0);
      if (mode[2] == 1 && k[2] > CI[2] + CN[2]) rsp[2] = 2'd1;
      step();
    end
    chk("drain_sig", 2, 32'(o_sig[2]), 'h3);

    // Reset in the middle of RUN.
    set_rsp(3);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (CI[0] + 3) step();
    chk("midrun_busy", 0, 32'(o_busy[0]), 1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("abort_busy", 0, 32'(o_busy[0]), 0);
    chk("abort_sig", 0, 32'(o_sig[0]), 0);
    chk("abort_pat", 0, 32'(o_pat[0]), 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      RST   = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 7) == 0);
      for (int d = 0; d < NI; d++)
        rsp[d] = 2'($urandom_range(0, (1 << CRW[d]) - 1));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end
endmodule
